// File: rtl/iq_sample_fifo.sv
// iq_sample_fifo: packs I/Q sample pairs into 32-bit words and buffers them.
// The read side is show-ahead and feeds the Ethernet packetizer.
// Storage is a synchronous-read RAM plus a prefetch stage (ram_q) and the rd_data output register.
// A word written into an empty FIFO reaches rd_data two edges later.
// Back-to-back pops advance rd_data on every edge.
module iq_sample_fifo #(
  parameter int unsigned SAMPLE_W     = 12,
  parameter int unsigned DEPTH_LOG2   = 9,
  parameter int unsigned READY_THRESH = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                s_valid,
  input  logic [SAMPLE_W-1:0] s_i,
  input  logic [SAMPLE_W-1:0] s_q,
  input  logic                rd_en,
  output logic [31:0]         rd_data,
  output logic                rd_dr,
  output logic [DEPTH_LOG2:0] fill,
  output logic                overflow,
  output logic [15:0]         ovf_count,
  input  logic                clr_ovf
);

  localparam int unsigned FILL_W    = DEPTH_LOG2 + 1;
  localparam int unsigned PTR_W     = DEPTH_LOG2;
  localparam int unsigned RAM_DEPTH = (2 ** DEPTH_LOG2) - 1;
  localparam logic [FILL_W-1:0] FULL_FILL = FILL_W'(2 ** DEPTH_LOG2);
  localparam logic [FILL_W-1:0] THRESH    = FILL_W'(READY_THRESH);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(RAM_DEPTH - 1);

  // State of the output register: EMPTY = nothing held, LOADING = words held but rd_data not yet valid.
  typedef enum logic [1:0] {EMPTY, LOADING, VALID} state_t;

  state_t             state;
  state_t             state_nxt_c;
  logic [31:0]        mem [RAM_DEPTH];
  logic [31:0]        ram_q;
  logic               q_vld;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   ram_cnt;

  logic               pop_c, wr_c, drop_c, out_vld_c;
  logic               pop_out_c, pop_q_c, pop_ram_c;
  logic               out_load_c, q_free_c, rd_issue_c, ram_adv_c, q_vld_nxt_c;
  logic [FILL_W-1:0]  fill_nxt_c;
  logic [PTR_W-1:0]   ram_cnt_nxt_c;
  logic [31:0]        word_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Sign-extend each sample to 16 bits: I in the upper half, Q in the lower half.
  assign word_c = {16'($signed(s_i)), 16'($signed(s_q))};

  // Accept/drop decision, prefetch pipeline moves and next occupancy.
  always_comb begin
    pop_c       = rd_en & (fill != '0);
    wr_c        = s_valid & en & ((fill != FULL_FILL) | pop_c);
    drop_c      = s_valid & en & ~wr_c;
    out_vld_c   = (state == VALID);
    // A pop takes the oldest word from whichever stage holds it, so fill stays exact
    // even when a consumer pops before rd_dr.
    pop_out_c   = pop_c & out_vld_c;
    pop_q_c     = pop_c & ~out_vld_c & q_vld;
    pop_ram_c   = pop_c & ~out_vld_c & ~q_vld;
    out_load_c  = (~out_vld_c | pop_out_c) & q_vld & ~pop_q_c;
    q_free_c    = ~q_vld | out_load_c | pop_q_c;
    rd_issue_c  = q_free_c & (ram_cnt != '0) & ~pop_ram_c;
    ram_adv_c   = rd_issue_c | pop_ram_c;
    q_vld_nxt_c = rd_issue_c | (q_vld & ~out_load_c & ~pop_q_c);

    fill_nxt_c = fill;
    if (wr_c && !pop_c) begin
      fill_nxt_c = fill + FILL_W'(1);
    end else if (!wr_c && pop_c) begin
      fill_nxt_c = fill - FILL_W'(1);
    end

    ram_cnt_nxt_c = ram_cnt;
    if (wr_c && !ram_adv_c) begin
      ram_cnt_nxt_c = ram_cnt + PTR_W'(1);
    end else if (!wr_c && ram_adv_c) begin
      ram_cnt_nxt_c = ram_cnt - PTR_W'(1);
    end

    state_nxt_c = EMPTY;
    if (out_load_c || (out_vld_c && !pop_out_c)) begin
      state_nxt_c = VALID;
    end else if (fill_nxt_c != '0) begin
      state_nxt_c = LOADING;
    end
  end

  // Sample RAM with a synchronous read into the prefetch stage.
  always_ff @(posedge clk) begin
    if (wr_c) begin
      mem[wr_ptr] <= word_c;
    end
    if (rd_issue_c) begin
      ram_q <= mem[rd_ptr];
    end
  end

  // Prefetch FSM, pointers, output register, fill and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      q_vld   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      rd_data <= '0;
      fill    <= '0;
      rd_dr   <= 1'b0;
    end else begin
      state   <= state_nxt_c;
      q_vld   <= q_vld_nxt_c;
      ram_cnt <= ram_cnt_nxt_c;
      fill    <= fill_nxt_c;
      rd_dr   <= (fill_nxt_c >= THRESH);
      if (wr_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (ram_adv_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (out_load_c) begin
        rd_data <= ram_q;
      end
    end
  end

  // Sticky drop flag and saturating drop counter; a drop in the clearing cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      ovf_count <= '0;
    end else if (clr_ovf) begin
      overflow  <= drop_c;
      ovf_count <= drop_c ? 16'd1 : 16'd0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (ovf_count != 16'hFFFF) begin
        ovf_count <= ovf_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_iq_sample_fifo.sv
// Directed bench for iq_sample_fifo with default parameters (12-bit samples, 512 words, threshold 128).
module tb_iq_sample_fifo;

  localparam int unsigned SAMPLE_W = 12;

  logic                clk;
  logic                rst;
  logic                en;
  logic                s_valid;
  logic [SAMPLE_W-1:0] s_i;
  logic [SAMPLE_W-1:0] s_q;
  logic                rd_en;
  logic [31:0]         rd_data;
  logic                rd_dr;
  logic [9:0]          fill;
  logic                overflow;
  logic [15:0]         ovf_count;
  logic                clr_ovf;

  int errors = 0;
  int checks = 0;

  iq_sample_fifo #(
    .SAMPLE_W    (12),
    .DEPTH_LOG2  (9),
    .READY_THRESH(128)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .s_valid  (s_valid),
    .s_i      (s_i),
    .s_q      (s_q),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_dr    (rd_dr),
    .fill     (fill),
    .overflow (overflow),
    .ovf_count(ovf_count),
    .clr_ovf  (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word for I=n, Q=~n (n < 2048): I is positive, ~n sign-extends to 0xFFFF-n.
  function automatic logic [31:0] exp_word(input int n);
    logic [15:0] hi;
    hi = 16'(n);
    return {hi, 16'hFFFF - hi};
  endfunction

  task automatic push(input int n);
    s_valid = 1'b1;
    s_i     = SAMPLE_W'(n);
    s_q     = ~SAMPLE_W'(n);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic drain(input int first, input int count, input string tag);
    for (int k = 0; k < count; k++) begin
      check(tag, rd_data, exp_word(first + k));
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b0; s_valid = 1'b0; s_i = '0; s_q = '0; rd_en = 1'b0; clr_ovf = 1'b0;
    tick(); tick(); tick();
    check("rst_rd_data", rd_data, 32'h0);
    check("rst_rd_dr", 32'(rd_dr), 32'h0);
    check("rst_fill", 32'(fill), 32'h0);
    check("rst_overflow", 32'(overflow), 32'h0);
    check("rst_ovf_count", 32'(ovf_count), 32'h0);
    rst = 1'b0;
    en  = 1'b1;
    tick();

    // T1: extreme samples pack with sign extension; word appears two edges after the write.
    s_valid = 1'b1; s_i = 12'h800; s_q = 12'h7FF;
    tick();
    s_valid = 1'b0;
    check("t1_fill", 32'(fill), 32'd1);
    check("t1_rd_dr", 32'(rd_dr), 32'h0);
    tick();
    check("t1_gap_rd_data", rd_data, 32'h0);
    tick();
    check("t1_pack", rd_data, 32'hF800_07FF);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t1_pop_fill", 32'(fill), 32'd0);
    check("t1_hold_rd_data", rd_data, 32'hF800_07FF);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("empty_pop_fill", 32'(fill), 32'd0);
    check("empty_pop_rd_data", rd_data, 32'hF800_07FF);
    check("empty_pop_overflow", 32'(overflow), 32'h0);

    // Capture disabled: strobes ignored and not counted as drops.
    en = 1'b0;
    push(5);
    check("en_low_fill", 32'(fill), 32'd0);
    check("en_low_overflow", 32'(overflow), 32'h0);
    en = 1'b1;

    // T2: ready threshold.
    for (int n = 0; n < 127; n++) push(n);
    check("t2_127_rd_dr", 32'(rd_dr), 32'h0);
    check("t2_127_fill", 32'(fill), 32'd127);
    push(127);
    check("t2_128_rd_dr", 32'(rd_dr), 32'h1);
    check("t2_128_fill", 32'(fill), 32'd128);
    check("t2_head", rd_data, exp_word(0));
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    check("t2_pop_rd_dr", 32'(rd_dr), 32'h0);
    check("t2_pop_fill", 32'(fill), 32'd127);
    drain(1, 127, "t2_order");
    check("t2_drained_fill", 32'(fill), 32'd0);

    // T3/T4: fill to capacity, then overflow accounting.
    for (int n = 0; n < 512; n++) push(n);
    check("t3_full_fill", 32'(fill), 32'd512);
    check("t3_full_rd_dr", 32'(rd_dr), 32'h1);
    check("t3_full_overflow", 32'(overflow), 32'h0);
    push(1000); push(1001); push(1002);
    check("t4_overflow", 32'(overflow), 32'h1);
    check("t4_ovf_count", 32'(ovf_count), 32'd3);
    check("t4_fill", 32'(fill), 32'd512);
    clr_ovf = 1'b1;
    push(1003);
    clr_ovf = 1'b0;
    check("t4_clr_drop_overflow", 32'(overflow), 32'h1);
    check("t4_clr_drop_count", 32'(ovf_count), 32'd1);
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("t4_clr_overflow", 32'(overflow), 32'h0);
    check("t4_clr_count", 32'(ovf_count), 32'd0);

    // T5: write and pop together at full.
    check("t5_head", rd_data, exp_word(0));
    rd_en = 1'b1;
    push(512);
    rd_en = 1'b0;
    check("t5_fill", 32'(fill), 32'd512);
    check("t5_no_drop", 32'(overflow), 32'h0);
    drain(1, 512, "t3_t5_order");
    check("t3_end_fill", 32'(fill), 32'd0);
    check("t3_end_rd_dr", 32'(rd_dr), 32'h0);

    // T6: asynchronous reset mid-burst.
    for (int n = 0; n < 200; n++) push(n);
    check("t6_pre_fill", 32'(fill), 32'd200);
    s_valid = 1'b1; s_i = 12'h055; s_q = 12'h0AA;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_fill", 32'(fill), 32'd0);
    check("t6_rst_rd_data", rd_data, 32'h0);
    check("t6_rst_rd_dr", 32'(rd_dr), 32'h0);
    check("t6_rst_overflow", 32'(overflow), 32'h0);
    check("t6_rst_ovf_count", 32'(ovf_count), 32'h0);
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    push(291);
    check("t6_post_fill", 32'(fill), 32'd1);
    tick();
    check("t6_post_gap", rd_data, 32'h0);
    tick();
    check("t6_post_rd_data", rd_data, exp_word(291));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
